// File: rtl/arm_shifter_pipe_if.sv
// Handshake and data bundle for the ARM barrel-shifter pipeline.
// The master drives an operation in and accepts the result; the slave
// (the shifter itself) does the reverse.
interface arm_shifter_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    // Upstream: operation request
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       shift_type;
    logic             imm_mode;
    logic [7:0]       amt;
    logic [WIDTH-1:0] rm;
    logic             carry_in;
    logic [TAG_W-1:0] tag_in;

    // Downstream: shifted operand toward the ALU
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, shift_type, imm_mode, amt, rm, carry_in, tag_in,
        output out_ready,
        input  in_ready,
        input  out_valid, result, carry_out, tag_out
    );

    modport slave (
        input  in_valid, shift_type, imm_mode, amt, rm, carry_in, tag_in,
        input  out_ready,
        output in_ready,
        output out_valid, result, carry_out, tag_out
    );
endinterface

// File: rtl/arm_shifter_pipe.sv
// Two-stage ARM data-processing barrel shifter (LSL/LSR/ASR/ROR/RRX).
// S1 folds the ARM amount/encoding corner cases into an effective op and a
// clamped amount so that S2 is a plain shift with no special cases beyond
// op selection. Valid/ready on both sides; the tag rides along unchanged.
module arm_shifter_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    arm_shifter_pipe_if.slave   bus
);

    localparam int LW = $clog2(WIDTH);      // bits of an immediate amount
    localparam int AW = $clog2(WIDTH + 2);  // holds an amount of 0..WIDTH+1

    localparam logic [8:0]  N_W     = 9'(WIDTH);
    localparam logic [AW-1:0] AMT_W   = AW'(WIDTH);
    localparam logic [AW-1:0] AMT_WP1 = AW'(WIDTH + 1);
    localparam logic [AW:0]   ROT_W   = (AW + 1)'(WIDTH);

    // Effective operation after normalisation
    typedef enum logic [2:0] {
        OP_PASS = 3'd0,   // result = rm, carry = carry_in
        OP_LSL  = 3'd1,
        OP_LSR  = 3'd2,
        OP_ASR  = 3'd3,
        OP_ROR  = 3'd4,
        OP_RRX  = 3'd5
    } op_e;

    // ------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    op_e              s1_op_q,    s1_op_d;
    logic [AW-1:0]    s1_amt_q,   s1_amt_d;
    logic [WIDTH-1:0] s1_rm_q,    s1_rm_d;
    logic             s1_cin_q,   s1_cin_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             carry_q,     carry_d;
    logic [TAG_W-1:0] tag_q,       tag_d;

    // ------------------------------------------------------------------
    // Combinational intermediates
    // ------------------------------------------------------------------
    logic             s2_load_s;
    logic             in_ready_s;
    logic             in_fire_s;

    logic [8:0]       n_s;          // raw amount, zero-extended
    logic [LW-1:0]    rot_s;        // n mod WIDTH
    op_e              norm_op_s;
    logic [AW-1:0]    norm_amt_s;

    logic [WIDTH:0]   lsl_s;        // {carry, result}
    logic [WIDTH:0]   lsr_s;        // {result, carry}
    logic [WIDTH:0]   asr_s;        // {result, carry}
    logic [AW:0]      ror_lsh_s;
    logic [WIDTH-1:0] ror_s;
    logic [WIDTH-1:0] shift_res_s;
    logic             shift_c_s;

    // Handshake: S2 refills when empty or draining; S1 refills when S2 takes its content
    always_comb begin
        s2_load_s  = !out_valid_q || bus.out_ready;
        in_ready_s = !s1_valid_q || s2_load_s;
        in_fire_s  = bus.in_valid && in_ready_s;
    end

    // Normalise: map ARM amount encodings to an effective op and a clamped amount
    always_comb begin
        norm_op_s  = OP_PASS;
        norm_amt_s = {AW{1'b0}};
        if (bus.imm_mode) begin
            n_s = 9'(bus.amt[LW-1:0]);
        end else begin
            n_s = {1'b0, bus.amt};
        end
        rot_s = n_s[LW-1:0];

        if (n_s == 9'd0) begin
            if (bus.imm_mode) begin
                // Immediate #0 encodes special cases for LSR/ASR/ROR
                case (bus.shift_type)
                    2'b00: begin
                        norm_op_s  = OP_PASS;
                        norm_amt_s = {AW{1'b0}};
                    end
                    2'b01: begin
                        norm_op_s  = OP_LSR;
                        norm_amt_s = AMT_W;
                    end
                    2'b10: begin
                        norm_op_s  = OP_ASR;
                        norm_amt_s = AMT_W;
                    end
                    2'b11: begin
                        norm_op_s  = OP_RRX;
                        norm_amt_s = {AW{1'b0}};
                    end
                    default: begin
                        norm_op_s  = OP_PASS;
                        norm_amt_s = {AW{1'b0}};
                    end
                endcase
            end else begin
                // Register amount of zero leaves operand and flag untouched
                norm_op_s  = OP_PASS;
                norm_amt_s = {AW{1'b0}};
            end
        end else begin
            case (bus.shift_type)
                2'b00: begin
                    // Anything beyond WIDTH+1 behaves like WIDTH+1 (all zero, C=0)
                    norm_op_s = OP_LSL;
                    if (n_s > N_W) begin
                        norm_amt_s = AMT_WP1;
                    end else begin
                        norm_amt_s = AW'(n_s);
                    end
                end
                2'b01: begin
                    norm_op_s = OP_LSR;
                    if (n_s > N_W) begin
                        norm_amt_s = AMT_WP1;
                    end else begin
                        norm_amt_s = AW'(n_s);
                    end
                end
                2'b10: begin
                    // ASR saturates at WIDTH: every bit becomes the sign
                    norm_op_s = OP_ASR;
                    if (n_s >= N_W) begin
                        norm_amt_s = AMT_W;
                    end else begin
                        norm_amt_s = AW'(n_s);
                    end
                end
                2'b11: begin
                    // A nonzero multiple of WIDTH rotates fully: rm back, C = rm[MSB]
                    norm_op_s = OP_ROR;
                    if (rot_s == {LW{1'b0}}) begin
                        norm_amt_s = AMT_W;
                    end else begin
                        norm_amt_s = AW'(rot_s);
                    end
                end
                default: begin
                    norm_op_s  = OP_PASS;
                    norm_amt_s = {AW{1'b0}};
                end
            endcase
        end
    end

    // S1 next state: capture a normalised operation on input accept
    always_comb begin
        if (in_ready_s) begin
            s1_valid_d = bus.in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (in_fire_s) begin
            s1_op_d  = norm_op_s;
            s1_amt_d = norm_amt_s;
            s1_rm_d  = bus.rm;
            s1_cin_d = bus.carry_in;
            s1_tag_d = bus.tag_in;
        end else begin
            s1_op_d  = s1_op_q;
            s1_amt_d = s1_amt_q;
            s1_rm_d  = s1_rm_q;
            s1_cin_d = s1_cin_q;
            s1_tag_d = s1_tag_q;
        end
    end

    // Shift datapath: amounts are already clamped, so each op is one shifter
    always_comb begin
        lsl_s     = {1'b0, s1_rm_q} << s1_amt_q;
        lsr_s     = {s1_rm_q, 1'b0} >> s1_amt_q;
        asr_s     = $unsigned($signed({s1_rm_q, 1'b0}) >>> s1_amt_q);
        ror_lsh_s = ROT_W - {1'b0, s1_amt_q};
        ror_s     = (s1_rm_q >> s1_amt_q) | (s1_rm_q << ror_lsh_s);

        case (s1_op_q)
            OP_LSL: begin
                shift_res_s = lsl_s[WIDTH-1:0];
                shift_c_s   = lsl_s[WIDTH];
            end
            OP_LSR: begin
                shift_res_s = lsr_s[WIDTH:1];
                shift_c_s   = lsr_s[0];
            end
            OP_ASR: begin
                shift_res_s = asr_s[WIDTH:1];
                shift_c_s   = asr_s[0];
            end
            OP_ROR: begin
                // Carry is the last bit rotated out, which lands in the MSB
                shift_res_s = ror_s;
                shift_c_s   = ror_s[WIDTH-1];
            end
            OP_RRX: begin
                shift_res_s = {s1_cin_q, s1_rm_q[WIDTH-1:1]};
                shift_c_s   = s1_rm_q[0];
            end
            OP_PASS: begin
                shift_res_s = s1_rm_q;
                shift_c_s   = s1_cin_q;
            end
            default: begin
                shift_res_s = s1_rm_q;
                shift_c_s   = s1_cin_q;
            end
        endcase
    end

    // S2 next state: outputs only move when S2 loads, so a stalled result holds
    always_comb begin
        if (s2_load_s) begin
            out_valid_d = s1_valid_q;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (s2_load_s && s1_valid_q) begin
            result_d = shift_res_s;
            carry_d  = shift_c_s;
            tag_d    = s1_tag_q;
        end else begin
            result_d = result_q;
            carry_d  = carry_q;
            tag_d    = tag_q;
        end
    end

    // Pipeline registers with synchronous reset discarding any in-flight op
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= OP_PASS;
            s1_amt_q    <= {AW{1'b0}};
            s1_rm_q     <= {WIDTH{1'b0}};
            s1_cin_q    <= 1'b0;
            s1_tag_q    <= {TAG_W{1'b0}};
            out_valid_q <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            tag_q       <= {TAG_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_amt_q    <= s1_amt_d;
            s1_rm_q     <= s1_rm_d;
            s1_cin_q    <= s1_cin_d;
            s1_tag_q    <= s1_tag_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_q;
    assign bus.tag_out   = tag_q;

endmodule

// File: tb/tb_arm_shifter_pipe.sv
// Directed self-checking bench for arm_shifter_pipe (WIDTH=32, TAG_W=4).
module tb_arm_shifter_pipe;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    arm_shifter_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

    arm_shifter_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic        im;
        logic [7:0]  a;
        logic [31:0] r;
        logic        ci;
        logic [31:0] er;
        logic        ec;
    } vec_t;

    // Drive one op with out_ready high and wait (bounded) for its result.
    // lat counts clock edges from the accepting edge; -1 means timeout.
    task automatic run_op(input logic [1:0] st, input logic im, input logic [7:0] a,
                          input logic [31:0] r, input logic ci, input logic [3:0] tg,
                          output logic [31:0] res, output logic c,
                          output logic [3:0] to, output int lat);
        @(posedge clk); #1;
        bus.in_valid   = 1'b1;
        bus.shift_type = st;
        bus.imm_mode   = im;
        bus.amt        = a;
        bus.rm         = r;
        bus.carry_in   = ci;
        bus.tag_in     = tg;
        bus.out_ready  = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            bus.in_valid = 1'b0;
        end while (!bus.out_valid && lat < 10);
        res = bus.result;
        c   = bus.carry_out;
        to  = bus.tag_out;
        if (!bus.out_valid) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h exp 0", bus.result); end
        n_checks++; if (bus.carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b exp 0", bus.carry_out); end
        n_checks++; if (bus.tag_out !== 4'h0) begin n_fail++; $display("FAIL reset_tag got %h exp 0", bus.tag_out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    endtask

    task automatic test_lsl();
        vec_t v [4];
        logic [31:0] res; logic c; logic [3:0] to; int lat;
        v[0] = '{2'b00, 1'b0, 8'd1,  32'h8000_0001, 1'b0, 32'h0000_0002, 1'b1};
        v[1] = '{2'b00, 1'b0, 8'd32, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1};
        v[2] = '{2'b00, 1'b0, 8'd33, 32'h8000_0001, 1'b0, 32'h0000_0000, 1'b0};
        v[3] = '{2'b00, 1'b0, 8'd4,  32'hF000_000F, 1'b0, 32'h0000_00F0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].st, v[i].im, v[i].a, v[i].r, v[i].ci, 4'(i + 1), res, c, to, lat);
            n_checks++; if (res !== v[i].er) begin n_fail++; $display("FAIL lsl[%0d] result got %h exp %h", i, res, v[i].er); end
            n_checks++; if (c !== v[i].ec) begin n_fail++; $display("FAIL lsl[%0d] carry got %b exp %b", i, c, v[i].ec); end
            n_checks++; if (to !== 4'(i + 1) || lat != 2) begin n_fail++; $display("FAIL lsl[%0d] tag/latency got %h/%0d exp %h/2", i, to, lat, 4'(i + 1)); end
        end
    endtask

    task automatic test_lsr_asr();
        vec_t v [5];
        logic [31:0] res; logic c; logic [3:0] to; int lat;
        v[0] = '{2'b10, 1'b0, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1};
        v[1] = '{2'b01, 1'b0, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1};
        v[2] = '{2'b01, 1'b0, 8'd4,   32'h1234_5678, 1'b0, 32'h0123_4567, 1'b1};
        v[3] = '{2'b10, 1'b0, 8'd4,   32'h8000_0010, 1'b1, 32'hF800_0001, 1'b0};
        v[4] = '{2'b01, 1'b0, 8'd32,  32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(v[i].st, v[i].im, v[i].a, v[i].r, v[i].ci, 4'(i + 6), res, c, to, lat);
            n_checks++; if (res !== v[i].er) begin n_fail++; $display("FAIL lsr_asr[%0d] result got %h exp %h", i, res, v[i].er); end
            n_checks++; if (c !== v[i].ec) begin n_fail++; $display("FAIL lsr_asr[%0d] carry got %b exp %b", i, c, v[i].ec); end
            n_checks++; if (to !== 4'(i + 6) || lat != 2) begin n_fail++; $display("FAIL lsr_asr[%0d] tag/latency got %h/%0d exp %h/2", i, to, lat, 4'(i + 6)); end
        end
    endtask

    task automatic test_ror();
        vec_t v [4];
        logic [31:0] res; logic c; logic [3:0] to; int lat;
        v[0] = '{2'b11, 1'b0, 8'd36, 32'h0000_00F1, 1'b1, 32'h1000_000F, 1'b0};
        v[1] = '{2'b11, 1'b0, 8'd64, 32'h0000_00F1, 1'b1, 32'h0000_00F1, 1'b0};
        v[2] = '{2'b11, 1'b0, 8'd1,  32'h8000_0001, 1'b0, 32'hC000_0000, 1'b1};
        v[3] = '{2'b11, 1'b0, 8'd0,  32'h0000_00F1, 1'b1, 32'h0000_00F1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_op(v[i].st, v[i].im, v[i].a, v[i].r, v[i].ci, 4'(i + 11), res, c, to, lat);
            n_checks++; if (res !== v[i].er) begin n_fail++; $display("FAIL ror[%0d] result got %h exp %h", i, res, v[i].er); end
            n_checks++; if (c !== v[i].ec) begin n_fail++; $display("FAIL ror[%0d] carry got %b exp %b", i, c, v[i].ec); end
            n_checks++; if (to !== 4'(i + 11) || lat != 2) begin n_fail++; $display("FAIL ror[%0d] tag/latency got %h/%0d exp %h/2", i, to, lat, 4'(i + 11)); end
        end
    endtask

    task automatic test_immediate();
        vec_t v [6];
        logic [31:0] res; logic c; logic [3:0] to; int lat;
        v[0] = '{2'b11, 1'b1, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1};
        v[1] = '{2'b01, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        v[2] = '{2'b10, 1'b1, 8'd0,   32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1};
        v[3] = '{2'b00, 1'b1, 8'd0,   32'h0000_0005, 1'b1, 32'h0000_0005, 1'b1};
        v[4] = '{2'b00, 1'b1, 8'hE1,  32'h4000_0001, 1'b1, 32'h8000_0002, 1'b0};
        v[5] = '{2'b11, 1'b1, 8'h24,  32'h0000_00F1, 1'b0, 32'h1000_000F, 1'b0};
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].st, v[i].im, v[i].a, v[i].r, v[i].ci, 4'(i + 2), res, c, to, lat);
            n_checks++; if (res !== v[i].er) begin n_fail++; $display("FAIL imm[%0d] result got %h exp %h", i, res, v[i].er); end
            n_checks++; if (c !== v[i].ec) begin n_fail++; $display("FAIL imm[%0d] carry got %b exp %b", i, c, v[i].ec); end
            n_checks++; if (to !== 4'(i + 2) || lat != 2) begin n_fail++; $display("FAIL imm[%0d] tag/latency got %h/%0d exp %h/2", i, to, lat, 4'(i + 2)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rm_tab  [4];
        logic [31:0] exp_res [4];
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit saw_block = 1'b0;
        bit extra = 1'b0;
        rm_tab[0] = 32'h0101_0101; exp_res[0] = 32'h0202_0202;
        rm_tab[1] = 32'h0202_0202; exp_res[1] = 32'h0404_0404;
        rm_tab[2] = 32'h0303_0303; exp_res[2] = 32'h0606_0606;
        rm_tab[3] = 32'h0404_0404; exp_res[3] = 32'h0808_0808;
        while (got < 4 && cyc < 40) begin
            @(posedge clk); #1;
            if (sent < 4) begin
                bus.in_valid   = 1'b1;
                bus.shift_type = 2'b00;
                bus.imm_mode   = 1'b0;
                bus.amt        = 8'd1;
                bus.rm         = rm_tab[sent];
                bus.carry_in   = 1'b1;
                bus.tag_in     = 4'(sent + 1);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (!bus.in_ready) saw_block = 1'b1;
            if (bus.out_valid) begin
                n_checks++;
                if (bus.result !== exp_res[got] || bus.tag_out !== 4'(got + 1) || bus.carry_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b cycle %0d got %h/tag %h/c %b exp %h/tag %h/c 0",
                             cyc, bus.result, bus.tag_out, bus.carry_out, exp_res[got], 4'(got + 1));
                end
                if (bus.out_ready) got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (got != 4 || sent != 4) begin n_fail++; $display("FAIL b2b_count got %0d sent %0d exp 4/4", got, sent); end
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL b2b_cycles got %0d exp 9", cyc); end
        n_checks++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_drop got %b exp 1", saw_block); end
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid) extra = 1'b1;
        end
        n_checks++; if (extra !== 1'b0) begin n_fail++; $display("FAIL b2b_duplicate got %b exp 0", extra); end
    endtask

    task automatic test_reset_mid_stall();
        logic [31:0] res; logic c; logic [3:0] to; int lat;
        bit stale = 1'b0;
        @(posedge clk); #1;
        bus.out_ready  = 1'b0;
        bus.in_valid   = 1'b1;
        bus.shift_type = 2'b00;
        bus.imm_mode   = 1'b0;
        bus.amt        = 8'd1;
        bus.rm         = 32'h0000_0001;
        bus.carry_in   = 1'b0;
        bus.tag_in     = 4'd5;
        @(posedge clk); #1;
        bus.rm     = 32'h0000_0002;
        bus.tag_in = 4'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_stall_setup got v%b r%b exp v1 r0", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_out_valid got %b exp 0", bus.out_valid); end
        n_checks++; if (bus.result !== 32'h0 || bus.tag_out !== 4'h0) begin n_fail++; $display("FAIL rst_stall_data got %h/%h exp 0/0", bus.result, bus.tag_out); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_stall_in_ready got %b exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        n_checks++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rst_stall_stale got %b exp 0", stale); end
        run_op(2'b01, 1'b0, 8'd8, 32'hA5A5_0000, 1'b0, 4'd9, res, c, to, lat);
        n_checks++; if (res !== 32'h00A5_A500 || c !== 1'b0 || to !== 4'd9 || lat != 2) begin
            n_fail++; $display("FAIL rst_stall_recover got %h/%b/%h/%0d exp 00a5a500/0/9/2", res, c, to, lat);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.shift_type = 2'b00;
        bus.imm_mode   = 1'b0;
        bus.amt        = 8'd0;
        bus.rm         = 32'h0;
        bus.carry_in   = 1'b0;
        bus.tag_in     = 4'h0;
        bus.out_ready  = 1'b1;
        test_reset();
        test_lsl();
        test_lsr_asr();
        test_ror();
        test_immediate();
        test_back_to_back();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
